// File: rtl/tconv_pkg.sv
// Shared definitions for the transposed-conv accumulation path: output-map field
// layout, accumulation pipeline depth, scheduler states and hazard-history entries.
package tconv_pkg;

  localparam int OMAP_W       = 14;
  localparam int OMAP_SEL_MSB = 13;
  localparam int OMAP_SEL_LSB = 10;
  localparam int OMAP_ADDR_W  = 9;
  localparam int OMAP_SEL_W   = OMAP_SEL_MSB - OMAP_SEL_LSB + 1;

  // A BRAM word is identified by {bram select, address}; bit 9 of an omap entry is spare.
  localparam int TGT_W = OMAP_SEL_W + OMAP_ADDR_W;

  localparam int ACC_PIPE_DEPTH = 6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } sched_state_e;

  typedef struct packed {
    logic             valid;
    logic [TGT_W-1:0] tgt;
  } hist_entry_t;

endpackage

// File: rtl/accum_drain_scheduler_hazard_window.sv
// History of recently issued BRAM targets with a parallel compare against the
// candidate target; 'hit' means issuing the candidate now would race an in-flight write.
module hazard_window
  import tconv_pkg::*;
#(
  parameter int DEPTH = ACC_PIPE_DEPTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_valid,
  input  logic [TGT_W-1:0] push_tgt,
  input  logic [TGT_W-1:0] probe_tgt,
  output logic             hit
);

  // The write issued DEPTH cycles ago commits on the same edge a new issue is
  // registered, so only the DEPTH-1 younger issues can still conflict.
  localparam int SLOTS = DEPTH - 1;

  hist_entry_t hist_q [SLOTS];
  hist_entry_t hist_d [SLOTS];

  // NOTE: every variable assigned in an always_comb gets a default first, so no path leaves it holding a value (no latch).
  always_comb begin
    hist_d[0].valid = push_valid;
    hist_d[0].tgt   = push_valid ? push_tgt : '0;
    for (int i = 1; i < SLOTS; i++) begin
      hist_d[i] = hist_q[i-1];
    end
  end

  // NOTE: the history is reset like any control state (not left as uninitialised storage): a stale valid entry would create phantom stalls.
  // NOTE: sequential state uses non-blocking assignments so all entries shift from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SLOTS; i++) begin
        hist_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < SLOTS; i++) begin
        hist_q[i] <= hist_d[i];
      end
    end
  end

  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < SLOTS; i++) begin
      if (hist_q[i].valid && (hist_q[i].tgt == probe_tgt)) begin
        hit = 1'b1;
      end
    end
  end

endmodule

// File: rtl/accum_drain_scheduler.sv
// Captures one systolic partial-sum vector and serialises its mapped columns into
// the accumulation unit, inserting bubbles on read-modify-write target hazards.
module accum_drain_scheduler
  import tconv_pkg::*;
#(
  parameter int DW        = 16,
  parameter int NUM_COLS  = 16,
  parameter int HAZ_DEPTH = ACC_PIPE_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       vec_valid,
  output logic                       vec_ready,
  input  logic [NUM_COLS*DW-1:0]     vec_flat,
  input  logic [NUM_COLS-1:0]        cmap,
  input  logic [NUM_COLS*OMAP_W-1:0] omap_flat,
  output logic [DW-1:0]              partial_out,
  output logic [3:0]                 col_id,
  output logic                       partial_valid,
  output logic [NUM_COLS-1:0]        cmap_out,
  output logic [NUM_COLS*OMAP_W-1:0] omap_out,
  output logic                       busy,
  output logic                       done,
  output logic [15:0]                stall_cnt
);

  localparam int CNT_W = $clog2(HAZ_DEPTH + 1);

  sched_state_e              state_q, state_d;
  logic [NUM_COLS-1:0]       pending_q, pending_d;
  logic [CNT_W-1:0]          drain_q, drain_d;
  logic [NUM_COLS*DW-1:0]    vec_q, vec_d;
  logic [NUM_COLS-1:0]       cmap_q, cmap_d;
  logic [NUM_COLS*OMAP_W-1:0] omap_q, omap_d;
  logic [DW-1:0]             out_q, out_d;
  logic [3:0]                col_q, col_d;
  logic                      pv_q, pv_d;
  logic                      done_q, done_d;
  logic [15:0]               stall_q, stall_d;

  logic [3:0]       col_sel;
  logic [TGT_W-1:0] probe_tgt;
  logic             hit;
  logic             issue_fire;
  logic             stall_bump;

  // Lowest pending column goes first; order is never changed around a blocked column.
  always_comb begin
    col_sel = '0;
    for (int i = NUM_COLS - 1; i >= 0; i--) begin
      if (pending_q[i]) col_sel = 4'(i);
    end
  end

  assign probe_tgt  = {omap_q[int'(col_sel)*OMAP_W + OMAP_SEL_LSB +: OMAP_SEL_W],
                       omap_q[int'(col_sel)*OMAP_W +: OMAP_ADDR_W]};
  assign issue_fire = (state_q == ST_ISSUE) && !hit;
  assign stall_bump = (state_q == ST_ISSUE) && hit;

  hazard_window #(
    .DEPTH (HAZ_DEPTH)
  ) u_hazard_window (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_valid (issue_fire),
    .push_tgt   (probe_tgt),
    .probe_tgt  (probe_tgt),
    .hit        (hit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      pending_q <= '0;
      drain_q   <= '0;
      vec_q     <= '0;
      cmap_q    <= '0;
      omap_q    <= '0;
      out_q     <= '0;
      col_q     <= '0;
      pv_q      <= 1'b0;
      done_q    <= 1'b0;
      stall_q   <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      drain_q   <= drain_d;
      vec_q     <= vec_d;
      cmap_q    <= cmap_d;
      omap_q    <= omap_d;
      out_q     <= out_d;
      col_q     <= col_d;
      pv_q      <= pv_d;
      done_q    <= done_d;
      stall_q   <= stall_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    drain_d   = drain_q;
    vec_d     = vec_q;
    cmap_d    = cmap_q;
    omap_d    = omap_q;
    case (state_q)
      ST_IDLE: begin
        if (vec_valid) begin
          vec_d     = vec_flat;
          cmap_d    = cmap;
          omap_d    = omap_flat;
          pending_d = cmap;
          if (cmap != '0) begin
            state_d = ST_ISSUE;
          end else begin
            // Nothing to write: skip straight to the done pulse.
            state_d = ST_DRAIN;
            drain_d = '0;
          end
        end
      end
      ST_ISSUE: begin
        if (!hit) begin
          pending_d[col_sel] = 1'b0;
          if (pending_d == '0) begin
            state_d = ST_DRAIN;
            drain_d = CNT_W'(HAZ_DEPTH);
          end
        end
      end
      ST_DRAIN: begin
        if (drain_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          drain_d = drain_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    out_d   = '0;
    col_d   = '0;
    pv_d    = 1'b0;
    done_d  = 1'b0;
    stall_d = stall_q;
    if (issue_fire) begin
      pv_d  = 1'b1;
      col_d = col_sel;
      out_d = vec_q[int'(col_sel)*DW +: DW];
    end
    if (stall_bump && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
    if ((state_q == ST_DRAIN) && (drain_q == '0)) begin
      done_d = 1'b1;
    end
  end

  assign vec_ready     = (state_q == ST_IDLE);
  assign busy          = (state_q != ST_IDLE);
  assign partial_out   = out_q;
  assign col_id        = col_q;
  assign partial_valid = pv_q;
  assign done          = done_q;
  assign stall_cnt     = stall_q;
  assign cmap_out      = cmap_q;
  assign omap_out      = omap_q;

endmodule

// File: tb/tb_accum_drain_scheduler.sv
// Randomised and directed bench for accum_drain_scheduler against an issue-time
// reference model built from per-target last-issue cycles.
module tb_accum_drain_scheduler;

  localparam int DW  = 16;
  localparam int NC  = 16;
  localparam int OW  = 14;
  localparam int HAZ = 6;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              vec_valid;
  logic              vec_ready;
  logic [NC*DW-1:0]  vec_flat;
  logic [NC-1:0]     cmap;
  logic [NC*OW-1:0]  omap_flat;
  logic [DW-1:0]     partial_out;
  logic [3:0]        col_id;
  logic              partial_valid;
  logic [NC-1:0]     cmap_out;
  logic [NC*OW-1:0]  omap_out;
  logic              busy;
  logic              done;
  logic [15:0]       stall_cnt;

  accum_drain_scheduler #(.DW(DW), .NUM_COLS(NC), .HAZ_DEPTH(HAZ)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .vec_valid     (vec_valid),
    .vec_ready     (vec_ready),
    .vec_flat      (vec_flat),
    .cmap          (cmap),
    .omap_flat     (omap_flat),
    .partial_out   (partial_out),
    .col_id        (col_id),
    .partial_valid (partial_valid),
    .cmap_out      (cmap_out),
    .omap_out      (omap_out),
    .busy          (busy),
    .done          (done),
    .stall_cnt     (stall_cnt)
  );

  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt++;

  int checks   = 0;
  int failures = 0;

  // Reference state: absolute edge of the most recent issue to each BRAM word.
  int last_issue [int];
  int stall_total = 0;

  int obs_issue_abs [NC];
  int obs_done_k;
  int t_cap;
  int acc_tgt = -1;
  logic [DW-1:0] obs_acc;

  function automatic int tgt_of(input logic [NC*OW-1:0] om, input int c);
    logic [OW-1:0] e;
    e = om[c*OW +: OW];
    return int'(e[13:10]) * 512 + int'(e[8:0]);
  endfunction

  function automatic logic [OW-1:0] omap_entry(input int sel, input int addr, input logic spare);
    logic [3:0] s;
    logic [8:0] a;
    s = sel[3:0];
    a = addr[8:0];
    return {s, spare, a};
  endfunction

  task automatic drive_garbage();
    vec_valid = 1'($urandom_range(0, 1));
    cmap      = NC'($urandom);
    for (int c = 0; c < NC; c++) begin
      vec_flat[c*DW +: DW]  = DW'($urandom);
      omap_flat[c*OW +: OW] = OW'($urandom);
    end
  endtask

  task automatic run_vector(input logic [NC-1:0] cm, input logic [NC*OW-1:0] om,
                            input logic [NC*DW-1:0] vv);
    int exp_k [NC];
    int prev, done_k, stalls, t, waited, nissued;
    logic          exp_pv;
    logic [3:0]    exp_col;
    logic [DW-1:0] exp_out;
    logic          exp_done;

    waited = 0;
    while (vec_ready !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (vec_ready !== 1'b1) begin
      failures++;
      $display("FAIL ready_wait: vec_ready=%b after %0d cycles, required 1", vec_ready, waited);
      vec_valid = 1'b0;
      return;
    end
    vec_valid = 1'b1;
    cmap      = cm;
    omap_flat = om;
    vec_flat  = vv;
    @(negedge clk);
    t_cap = edge_cnt;

    // Each mapped column issues at the first edge after its predecessor that is
    // at least HAZ edges after the last issue to the same BRAM word.
    prev = t_cap;
    stalls = 0;
    nissued = 0;
    for (int c = 0; c < NC; c++) begin
      exp_k[c] = -1;
      if (cm[c]) begin
        t = tgt_of(om, c);
        exp_k[c] = prev + 1;
        if (last_issue.exists(t) && (last_issue[t] + HAZ > exp_k[c])) exp_k[c] = last_issue[t] + HAZ;
        stalls += exp_k[c] - (prev + 1);
        last_issue[t] = exp_k[c];
        prev = exp_k[c];
        exp_k[c] -= t_cap;
        nissued++;
      end
    end
    done_k = (nissued == 0) ? 1 : (prev - t_cap) + HAZ + 1;
    stall_total = (stall_total + stalls > 65535) ? 65535 : stall_total + stalls;

    checks++;
    if (cmap_out !== cm || omap_out !== om || busy !== 1'b1) begin
      failures++;
      $display("FAIL capture: cmap_out=%h busy=%b, required cmap_out=%h busy=1 (omap match=%b)",
               cmap_out, busy, cm, omap_out === om);
    end

    for (int c = 0; c < NC; c++) obs_issue_abs[c] = -1;
    obs_done_k = -1;
    obs_acc = '0;
    drive_garbage();

    for (int k = 1; k <= done_k; k++) begin
      @(negedge clk);
      exp_pv = 1'b0; exp_col = '0; exp_out = '0;
      for (int c = 0; c < NC; c++) begin
        if (exp_k[c] == k) begin
          exp_pv = 1'b1; exp_col = 4'(c); exp_out = vv[c*DW +: DW];
        end
      end
      exp_done = (k == done_k);
      checks++;
      if ({partial_valid, col_id, partial_out, done} !== {exp_pv, exp_col, exp_out, exp_done}) begin
        failures++;
        $display("FAIL issue_k%0d: valid=%b col=%0d data=%h done=%b, required valid=%b col=%0d data=%h done=%b",
                 k, partial_valid, col_id, partial_out, done, exp_pv, exp_col, exp_out, exp_done);
      end
      if (partial_valid === 1'b1) begin
        obs_issue_abs[col_id] = edge_cnt;
        if (tgt_of(om, int'(col_id)) == acc_tgt) obs_acc += partial_out;
      end
      if (done === 1'b1 && obs_done_k < 0) obs_done_k = k;
      if (k < done_k) drive_garbage();
      else vec_valid = 1'b0;
    end

    checks++;
    if (stall_cnt !== 16'(stall_total) || busy !== 1'b0 || cmap_out !== cm) begin
      failures++;
      $display("FAIL vector_end: stall_cnt=%0d busy=%b cmap_out=%h, required stall_cnt=%0d busy=0 cmap_out=%h",
               stall_cnt, busy, cmap_out, stall_total, cm);
    end
  endtask

  task automatic make_random(output logic [NC-1:0] cm, output logic [NC*OW-1:0] om,
                             output logic [NC*DW-1:0] vv);
    cm = ($urandom_range(0, 7) == 0) ? '0 : NC'($urandom);
    for (int c = 0; c < NC; c++) begin
      om[c*OW +: OW] = omap_entry($urandom_range(0, 1), $urandom_range(0, 3), 1'($urandom));
      vv[c*DW +: DW] = DW'($urandom);
    end
  endtask

  task automatic distinct_omap(output logic [NC*OW-1:0] om);
    for (int c = 0; c < NC; c++) om[c*OW +: OW] = omap_entry(c, 0, 1'b0);
  endtask

  task automatic random_vec(output logic [NC*DW-1:0] vv);
    for (int c = 0; c < NC; c++) vv[c*DW +: DW] = DW'($urandom);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; vec_valid = 1'b0; cmap = '0; omap_flat = '0; vec_flat = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({vec_ready, busy, partial_valid, done, col_id, partial_out, stall_cnt} !== {1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 16'd0, 16'd0}
        || cmap_out !== '0 || omap_out !== '0) begin
      failures++;
      $display("FAIL reset_values: ready=%b busy=%b valid=%b done=%b col=%0d data=%h stall=%0d, required ready=1 others 0",
               vec_ready, busy, partial_valid, done, col_id, partial_out, stall_cnt);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (vec_ready !== 1'b1 || busy !== 1'b0 || partial_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: ready=%b busy=%b valid=%b, required 1 0 0", vec_ready, busy, partial_valid);
    end
  endtask

  task automatic test_all_columns();
    logic [NC*OW-1:0] om;
    logic [NC*DW-1:0] vv;
    distinct_omap(om);
    random_vec(vv);
    run_vector(16'hFFFF, om, vv);
    for (int c = 0; c < NC; c++) begin
      checks++;
      if (obs_issue_abs[c] - t_cap !== c + 1) begin
        failures++;
        $display("FAIL all_cols_order: col %0d at T+%0d, required T+%0d", c, obs_issue_abs[c] - t_cap, c + 1);
      end
    end
    checks++;
    if (obs_done_k !== 23 || stall_cnt !== 16'd0) begin
      failures++;
      $display("FAIL all_cols_done: done at T+%0d stall=%0d, required T+23 stall=0", obs_done_k, stall_cnt);
    end
  endtask

  task automatic test_empty();
    logic [NC*OW-1:0] om;
    logic [NC*DW-1:0] vv;
    distinct_omap(om);
    random_vec(vv);
    run_vector('0, om, vv);
    checks++;
    if (obs_done_k !== 1) begin
      failures++;
      $display("FAIL empty_done: done at T+%0d, required T+1", obs_done_k);
    end
  endtask

  task automatic test_same_target();
    logic [NC*OW-1:0] om;
    logic [NC*DW-1:0] vv;
    logic [DW-1:0]    want;
    int               stall_before;
    distinct_omap(om);
    om[0*OW +: OW] = omap_entry(3, 16, 1'b0);
    om[2*OW +: OW] = omap_entry(3, 16, 1'b0);
    random_vec(vv);
    want = vv[0 +: DW] + vv[2*DW +: DW];
    acc_tgt = 3 * 512 + 16;
    stall_before = stall_total;
    run_vector(16'h0005, om, vv);
    acc_tgt = -1;
    checks++;
    if (obs_issue_abs[0] - t_cap !== 1 || obs_issue_abs[2] - t_cap !== 7) begin
      failures++;
      $display("FAIL same_target_timing: col0 T+%0d col2 T+%0d, required T+1 and T+7",
               obs_issue_abs[0] - t_cap, obs_issue_abs[2] - t_cap);
    end
    checks++;
    if (int'(stall_cnt) !== stall_before + 5 || obs_acc !== want) begin
      failures++;
      $display("FAIL same_target_stall_acc: stall=%0d acc=%h, required stall=%0d acc=%h",
               stall_cnt, obs_acc, stall_before + 5, want);
    end
  endtask

  task automatic test_edge_columns();
    logic [NC*OW-1:0] om;
    logic [NC*DW-1:0] vv;
    distinct_omap(om);
    random_vec(vv);
    run_vector(16'h8001, om, vv);
    checks++;
    if (obs_issue_abs[0] - t_cap !== 1 || obs_issue_abs[15] - t_cap !== 2) begin
      failures++;
      $display("FAIL edge_cols: col0 T+%0d col15 T+%0d, required T+1 and T+2",
               obs_issue_abs[0] - t_cap, obs_issue_abs[15] - t_cap);
    end
  endtask

  task automatic test_back_to_back();
    logic [NC*OW-1:0] om;
    logic [NC*DW-1:0] vv;
    int               a_issue;
    distinct_omap(om);
    om[15*OW +: OW] = omap_entry(7, 200, 1'b0);
    om[0*OW +: OW]  = omap_entry(7, 200, 1'b0);
    random_vec(vv);
    run_vector(16'h8000, om, vv);
    a_issue = obs_issue_abs[15];
    random_vec(vv);
    run_vector(16'h0001, om, vv);
    checks++;
    if (a_issue < 0 || obs_issue_abs[0] < 0 || obs_issue_abs[0] - a_issue < HAZ) begin
      failures++;
      $display("FAIL back_to_back: A col15 edge %0d, B col0 edge %0d, required gap >= %0d",
               a_issue, obs_issue_abs[0], HAZ);
    end
  endtask

  task automatic test_random();
    logic [NC-1:0]    cm;
    logic [NC*OW-1:0] om;
    logic [NC*DW-1:0] vv;
    for (int n = 0; n < 14; n++) begin
      make_random(cm, om, vv);
      run_vector(cm, om, vv);
    end
  endtask

  task automatic test_reset_mid();
    logic [NC*OW-1:0] om;
    logic [NC*DW-1:0] vv;
    int               seen, guard;
    distinct_omap(om);
    random_vec(vv);
    checks++;
    if (vec_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_ready: vec_ready=%b, required 1", vec_ready);
    end
    vec_valid = 1'b1; cmap = 16'hFFFF; omap_flat = om; vec_flat = vv;
    @(negedge clk);
    vec_valid = 1'b0;
    seen = 0; guard = 0;
    while (seen < 3 && guard < 20) begin
      @(negedge clk);
      if (partial_valid === 1'b1) seen++;
      guard++;
    end
    checks++;
    if (seen !== 3) begin
      failures++;
      $display("FAIL reset_mid_issues: saw %0d issues, required 3", seen);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({vec_ready, busy, partial_valid, done, col_id, partial_out, stall_cnt} !== {1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 16'd0, 16'd0}
        || cmap_out !== '0 || omap_out !== '0) begin
      failures++;
      $display("FAIL reset_mid_outputs: ready=%b busy=%b valid=%b done=%b col=%0d data=%h stall=%0d, required ready=1 others 0",
               vec_ready, busy, partial_valid, done, col_id, partial_out, stall_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    last_issue.delete();
    stall_total = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || partial_valid !== 1'b0 || vec_ready !== 1'b1) begin
        failures++;
        $display("FAIL reset_mid_quiet_%0d: done=%b valid=%b ready=%b, required 0 0 1",
                 k, done, partial_valid, vec_ready);
      end
    end
  endtask

  initial begin
    test_reset();
    test_all_columns();
    test_empty();
    test_same_target();
    test_edge_columns();
    test_back_to_back();
    test_random();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
